// File: rtl/sort_unpack_if.sv
// Group-in / element-out stream bundle between the sorter and the unpacker.
interface sort_unpack_if;
    logic       in_valid;
    logic [4:0] in_number1;
    logic [4:0] in_number2;
    logic [4:0] in_number3;
    logic [4:0] in_number4;
    logic       out_ready;
    logic       out_valid;
    logic [4:0] out_number;
    logic       out_last;
    logic       full;
    logic       overflow;

    modport master (
        output in_valid, in_number1, in_number2,
        output in_number3, in_number4, out_ready,
        input  out_valid, out_number, out_last,
        input  full, overflow
    );

    modport slave (
        input  in_valid, in_number1, in_number2,
        input  in_number3, in_number4, out_ready,
        output out_valid, out_number, out_last,
        output full, overflow
    );
endinterface

// File: rtl/sort_unpack.sv
// Buffers sorted groups of four and re-emits them one element per cycle.
// Define SORT_UNPACK_ASCEND_EN to emit smallest-first instead of largest-first.
module sort_unpack #(
    parameter int DEPTH = 4
) (
    input logic         clk,
    input logic         rst_n,
    sort_unpack_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [4:0]    mem [DEPTH][4];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    idx;
    logic [1:0]    sel;
    logic          overflow_q;
    logic          valid;
    logic          xfer;
    logic          pop;
    logic          wr_ok;

    assign valid = (count != '0);
    assign xfer  = valid && bus.out_ready;
    assign pop   = xfer && (idx == 2'd3);
    // A full FIFO still takes a group when the head leaves on the same edge.
    assign wr_ok = bus.in_valid && ((count != FULL_CNT) || pop);

`ifdef SORT_UNPACK_ASCEND_EN
    assign sel = ~idx;
`else
    assign sel = idx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < 4; j++) begin
                    mem[i][j] <= '0;
                end
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            idx        <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr][0] <= bus.in_number1;
                mem[wr_ptr][1] <= bus.in_number2;
                mem[wr_ptr][2] <= bus.in_number3;
                mem[wr_ptr][3] <= bus.in_number4;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                idx    <= '0;
            end else if (xfer) begin
                idx <= idx + 1'b1;
            end
            if (wr_ok && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !wr_ok) begin
                count <= count - CW'(1);
            end
            if (bus.in_valid && !wr_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.out_valid  = valid;
    assign bus.out_number = valid ? mem[rd_ptr][sel] : 5'd0;
    assign bus.out_last   = valid && (idx == 2'd3);
    assign bus.full       = (count == FULL_CNT);
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_sort_unpack.sv
// Directed bench for sort_unpack: vector table plus multi-cycle corner cases.
module tb_sort_unpack;
    typedef logic [3:0][4:0] grp_t;
    typedef struct {
        grp_t grp;
        grp_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sort_unpack_if bus ();

    sort_unpack #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic grp_t mk(input logic [4:0] a, input logic [4:0] b,
                                input logic [4:0] c, input logic [4:0] d);
        grp_t g;
        g[0] = a;
        g[1] = b;
        g[2] = c;
        g[3] = d;
        return g;
    endfunction

    // Expected k-th emitted element of a group stored as number1..number4.
    function automatic logic [4:0] el(input grp_t g, input int k);
`ifdef SORT_UNPACK_ASCEND_EN
        return g[3-k];
`else
        return g[k];
`endif
    endfunction

    task automatic send(input grp_t g);
        bus.in_valid   = 1'b1;
        bus.in_number1 = g[0];
        bus.in_number2 = g[1];
        bus.in_number3 = g[2];
        bus.in_number4 = g[3];
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    vec_t vt[4];
    grp_t fg[5];
    grp_t g;
    grp_t ng;
    logic [4:0] got[$];
    logic [4:0] want[$];
    logic prev_valid, prev_rdy, rdy, injected, just_inj;
    logic [4:0] prev_num;

    initial begin
        vt[0].grp = mk(20, 15, 9, 3);
        vt[1].grp = mk(31, 30, 1, 0);
        vt[2].grp = mk(7, 7, 7, 7);
        vt[3].grp = mk(16, 8, 4, 2);
`ifdef SORT_UNPACK_ASCEND_EN
        vt[0].exp = mk(3, 9, 15, 20);
        vt[1].exp = mk(0, 1, 30, 31);
        vt[2].exp = mk(7, 7, 7, 7);
        vt[3].exp = mk(2, 4, 8, 16);
`else
        vt[0].exp = mk(20, 15, 9, 3);
        vt[1].exp = mk(31, 30, 1, 0);
        vt[2].exp = mk(7, 7, 7, 7);
        vt[3].exp = mk(16, 8, 4, 2);
`endif
        for (int i = 0; i < 5; i++) begin
            fg[i] = mk(5'(4*i+3), 5'(4*i+2), 5'(4*i+1), 5'(4*i));
        end

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_number1 = '0;
        bus.in_number2 = '0;
        bus.in_number3 = '0;
        bus.in_number4 = '0;
        bus.out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 8'(bus.out_valid), 8'd0);
        chk("rst_number", 8'(bus.out_number), 8'd0);
        chk("rst_last", 8'(bus.out_last), 8'd0);
        chk("rst_full", 8'(bus.full), 8'd0);
        chk("rst_overflow", 8'(bus.overflow), 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: one group at a time, ready held high.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(vt[i].grp);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("vec%0d_valid%0d", i, k),
                    8'(bus.out_valid), 8'd1);
                chk($sformatf("vec%0d_num%0d", i, k),
                    8'(bus.out_number), 8'(vt[i].exp[k]));
                chk($sformatf("vec%0d_last%0d", i, k),
                    8'(bus.out_last), 8'(k == 3));
                @(negedge clk);
            end
            chk($sformatf("vec%0d_idle", i), 8'(bus.out_valid), 8'd0);
        end

        // Ready toggling 1,0,0,... while a group drains.
        bus.out_ready = 1'b0;
        g = mk(25, 18, 11, 2);
        send(g);
        got.delete();
        prev_valid = 1'b0;
        prev_rdy   = 1'b1;
        prev_num   = '0;
        for (int c = 0; c < 30; c++) begin
            if (!prev_rdy && prev_valid) begin
                chk("hold_valid", 8'(bus.out_valid), 8'd1);
                chk("hold_num", 8'(bus.out_number), 8'(prev_num));
            end
            rdy = (c % 3 == 0);
            bus.out_ready = rdy;
            if (bus.out_valid && rdy) got.push_back(bus.out_number);
            prev_valid = bus.out_valid;
            prev_num   = bus.out_number;
            prev_rdy   = rdy;
            @(negedge clk);
        end
        chk("tog_count", 8'(got.size()), 8'd4);
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            chk($sformatf("tog_el%0d", k), 8'(got[k]), 8'(el(g, k)));
        end

        // Fill to DEPTH with ready low, fifth group dropped.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(fg[i]);
            if (i == 3) begin
                chk("fill_full", 8'(bus.full), 8'd1);
                chk("fill_noovf", 8'(bus.overflow), 8'd0);
            end
        end
        chk("drop_full", 8'(bus.full), 8'd1);
        chk("drop_ovf", 8'(bus.overflow), 8'd1);
        bus.out_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            chk($sformatf("drain_valid%0d", n), 8'(bus.out_valid), 8'd1);
            chk($sformatf("drain_num%0d", n), 8'(bus.out_number),
                8'(el(fg[n/4], n%4)));
            @(negedge clk);
        end
        chk("drain_idle", 8'(bus.out_valid), 8'd0);
        chk("drain_notfull", 8'(bus.full), 8'd0);
        chk("drain_ovf_sticky", 8'(bus.overflow), 8'd1);

        // Full FIFO, new group on the edge that pops the head.
        do_reset();
        for (int i = 0; i < 4; i++) send(fg[i]);
        chk("sim_full", 8'(bus.full), 8'd1);
        bus.out_ready = 1'b1;
        ng = mk(31, 31, 0, 0);
        got.delete();
        injected = 1'b0;
        for (int c = 0; c < 40; c++) begin
            just_inj = 1'b0;
            if (bus.out_valid) got.push_back(bus.out_number);
            if (bus.out_valid && bus.out_last && !injected) begin
                bus.in_valid   = 1'b1;
                bus.in_number1 = ng[0];
                bus.in_number2 = ng[1];
                bus.in_number3 = ng[2];
                bus.in_number4 = ng[3];
                injected = 1'b1;
                just_inj = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (just_inj) begin
                chk("sim_still_full", 8'(bus.full), 8'd1);
                chk("sim_noovf", 8'(bus.overflow), 8'd0);
            end
        end
        bus.in_valid = 1'b0;
        want.delete();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) want.push_back(el(fg[i], k));
        for (int k = 0; k < 4; k++) want.push_back(el(ng, k));
        chk("sim_count", 8'(got.size()), 8'd20);
        for (int n = 0; n < 20 && n < got.size(); n++) begin
            chk($sformatf("sim_el%0d", n), 8'(got[n]), 8'(want[n]));
        end
        chk("sim_end_ovf", 8'(bus.overflow), 8'd0);

        // Reset mid-group at idx 2.
        do_reset();
        bus.out_ready = 1'b1;
        g = mk(21, 14, 6, 1);
        send(g);
        @(negedge clk);
        @(negedge clk);
        chk("mid_idx2", 8'(bus.out_number), 8'(el(g, 2)));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 8'(bus.out_valid), 8'd0);
        chk("mid_rst_num", 8'(bus.out_number), 8'd0);
        chk("mid_rst_last", 8'(bus.out_last), 8'd0);
        chk("mid_rst_full", 8'(bus.full), 8'd0);
        chk("mid_rst_ovf", 8'(bus.overflow), 8'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_lost", 8'(bus.out_valid), 8'd0);
        g = mk(10, 9, 8, 7);
        send(g);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("post_num%0d", k), 8'(bus.out_number),
                8'(el(g, k)));
            chk($sformatf("post_last%0d", k), 8'(bus.out_last),
                8'(k == 3));
            @(negedge clk);
        end
        chk("post_idle", 8'(bus.out_valid), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
